pipe_stage_chain: RTL and testbench

- Parametrised successor to the CPU's hand-instantiated per-signal pipeline latches: DEPTH back-to-back stages of WIDTH-bit payload, each with a valid bit.
- Uses valid/ready flow control with bubble collapsing, so a downstream stall (e.g. cache miss) only freezes occupied stages.
- Supports a per-stage kill mask for branch/jump flush and occupancy/kill statistics.
- Replaces the IF/ID…MEM/WB latch groups with one configurable block.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_stage_slot.sv | 34 +++
 rtl/pipe_stage_chain.sv | 121 ++++++++++++
 tb/tb_pipe_stage_chain.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe_stage_chain block: constant clog2, popcount and a
// saturating adder for the statistics counters.
package pipe_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] x);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) c = c + {6'b0, x[i]};
        return c;
    endfunction

    // Adds b to a, clamping at 2^w-1 instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [6:0] b, input int w);
        logic [63:0] lim;
        logic [63:0] s;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        s = a + {57'b0, b};
        if (s > lim || s < a) s = lim;
        return s;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline stage: valid/data registers plus its effective-valid and
// accept terms in the bubble-collapsing chain.
module pipe_stage_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             flush,
    input  logic             acc_next,
    output logic             ev,
    output logic             acc,
    output logic             v,
    output logic             v_nxt,
    output logic [WIDTH-1:0] d
);

    // A killed item counts as a bubble this cycle, so the slot can refill at once.
    assign ev    = v & ~flush;
    assign acc   = ~ev | acc_next;
    assign v_nxt = acc ? src_valid : ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            v <= v_nxt;
            if (acc && src_valid) d <= src_data;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/ready pipeline with bubble collapsing, per-stage kill mask,
// occupancy and saturating kill statistics. Optional input skid register under
// PIPE_STAGE_CHAIN_SKID_BUFFER_EN.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    input  logic [DEPTH-1:0]            flush_mask,
    output logic [clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]            kill_count
);

    localparam int OCC_W = clog2(DEPTH + 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and data is only meaningful with valid.
    logic [DEPTH-1:0] v_vec;
    logic [DEPTH-1:0] v_nxt_vec;
    logic             acc0;
    logic             s0_valid;
    logic [WIDTH-1:0] s0_data;
    logic             kill_extra;

`ifdef PIPE_STAGE_CHAIN_SKID_BUFFER_EN
    logic             sv;
    logic [WIDTH-1:0] sd;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready   = ~sv;
    assign s0_valid   = sv ? ~flush_mask[0] : in_valid;
    assign s0_data    = sv ? sd : in_data;
    assign kill_extra = sv & flush_mask[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= 1'b0;
            sd <= '0;
        end else if (sv) begin
            sv <= ~acc0 & ~flush_mask[0];
        end else begin
            sv <= in_valid & ~acc0;
            if (in_valid && !acc0) sd <= in_data;
        end
    end
`else
    assign in_ready   = acc0;
    assign s0_valid   = in_valid & acc0;
    assign s0_data    = in_data;
    assign kill_extra = 1'b0;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             ev;
        logic             acc;
        logic             acc_next;
        logic             v;
        logic             v_nxt;
        logic             src_valid;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] src_data;

        if (i == DEPTH - 1) begin : g_tail
            assign acc_next = out_ready;
        end else begin : g_link
            assign acc_next = g_stage[i+1].acc;
        end

        if (i == 0) begin : g_head
            assign src_valid = s0_valid;
            assign src_data  = s0_data;
        end else begin : g_body
            assign src_valid = g_stage[i-1].ev;
            assign src_data  = g_stage[i-1].d;
        end

        pipe_stage_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .src_valid (src_valid),
            .src_data  (src_data),
            .flush     (flush_mask[i]),
            .acc_next  (acc_next),
            .ev        (ev),
            .acc       (acc),
            .v         (v),
            .v_nxt     (v_nxt),
            .d         (d)
        );

        assign v_vec[i]     = v;
        assign v_nxt_vec[i] = v_nxt;
    end

    assign acc0      = g_stage[0].acc;
    assign out_valid = g_stage[DEPTH-1].ev;
    assign out_data  = g_stage[DEPTH-1].d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy  <= '0;
            kill_count <= '0;
        end else begin
            occupancy  <= OCC_W'(popcount(64'(v_nxt_vec)));
            kill_count <= CNT_W'(sat_add(64'(kill_count),
                                         popcount(64'(v_vec & flush_mask)) + {6'b0, kill_extra},
                                         CNT_W));
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: item-level pipeline model checked every cycle,
// directed scenarios with literal expectations and an output-order scoreboard.
module tb_pipe_stage_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [DEPTH-1:0] flush_mask;
    logic [2:0]       occupancy;
    logic [CNT_W-1:0] kill_count;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    // Model: each slot holds at most one item; every cycle kills drop items,
    // the output slot may be consumed, every item steps into a free next slot,
    // then the front slot (or the skid) takes the input.
    bit               m_v[DEPTH];
    logic [WIDTH-1:0] m_d[DEPTH];
    bit               m_sv;
    logic [WIDTH-1:0] m_sd;
    int               m_occ;
    int               m_kill;
    bit               n_v[DEPTH];
    logic [WIDTH-1:0] n_d[DEPTH];
    bit               n_sv;
    logic [WIDTH-1:0] n_sd;
    int               n_occ;
    int               n_kill;
    bit               x_rdy;

    pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush_mask (flush_mask),
        .occupancy  (occupancy),
        .kill_count (kill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_sv   = 1'b0;
        m_sd   = '0;
        m_occ  = 0;
        m_kill = 0;
    endtask

    task automatic model_eval();
        int k;
        k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            n_v[i] = m_v[i];
            n_d[i] = m_d[i];
        end
        n_sv = m_sv;
        n_sd = m_sd;
        for (int i = 0; i < DEPTH; i++) begin
            if (n_v[i] && flush_mask[i]) begin
                n_v[i] = 1'b0;
                k++;
            end
        end
`ifdef PIPE_STAGE_CHAIN_SKID_BUFFER_EN
        if (n_sv && flush_mask[0]) begin
            n_sv = 1'b0;
            k++;
        end
`endif
        if (n_v[DEPTH-1] && out_ready) n_v[DEPTH-1] = 1'b0;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (n_v[i] && !n_v[i+1]) begin
                n_v[i+1] = 1'b1;
                n_d[i+1] = n_d[i];
                n_v[i]   = 1'b0;
            end
        end
`ifdef PIPE_STAGE_CHAIN_SKID_BUFFER_EN
        x_rdy = !m_sv;
        if (n_sv) begin
            if (!n_v[0]) begin
                n_v[0] = 1'b1;
                n_d[0] = n_sd;
                n_sv   = 1'b0;
            end
        end else if (in_valid && x_rdy) begin
            if (!n_v[0]) begin
                n_v[0] = 1'b1;
                n_d[0] = in_data;
            end else begin
                n_sv = 1'b1;
                n_sd = in_data;
            end
        end
`else
        x_rdy = !n_v[0];
        if (in_valid && x_rdy) begin
            n_v[0] = 1'b1;
            n_d[0] = in_data;
        end
`endif
        n_occ = 0;
        for (int i = 0; i < DEPTH; i++) if (n_v[i]) n_occ++;
        n_kill = m_kill + k;
        if (n_kill > (1 << CNT_W) - 1) n_kill = (1 << CNT_W) - 1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        model_eval();
        chk("out_valid", 64'(out_valid), 64'(m_v[DEPTH-1] && !flush_mask[DEPTH-1]));
        if (m_v[DEPTH-1] && !flush_mask[DEPTH-1])
            chk("out_data", 64'(out_data), 64'(m_d[DEPTH-1]));
        chk("in_ready", 64'(in_ready), 64'(x_rdy));
        chk("occupancy", 64'(occupancy), 64'(m_occ));
        chk("kill_count", 64'(kill_count), 64'(m_kill));
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_extra", 64'(out_data), 64'hDEAD_0000_0000);
            else chk("sb_order", 64'(out_data), 64'(exp_q.pop_front()));
        end
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_v[i] = n_v[i];
                m_d[i] = n_d[i];
            end
            m_sv   = n_sv;
            m_sd   = n_sd;
            m_occ  = n_occ;
            m_kill = n_kill;
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush_mask = '0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_kill_count", 64'(kill_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;

        // streaming 1..8 with out_ready held high
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) exp_q.push_back(WIDTH'(k));
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_data  = WIDTH'(c + 1);
            @(negedge clk);
            if (c < 8) chk("stream_in_ready", 64'(in_ready), 64'd1);
            if (c >= 4) begin
                chk("stream_out_valid", 64'(out_valid), 64'd1);
                chk("stream_out_data", 64'(out_data), 64'(c - 3));
            end
            tick();
        end
        in_valid = 1'b0;

        // backpressure: fill four, hold, then release
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(32'h11 + k);
            exp_q.push_back(WIDTH'(32'h11 + k));
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_occupancy", 64'(occupancy), 64'd4);
`ifdef PIPE_STAGE_CHAIN_SKID_BUFFER_EN
        chk("bp_in_ready", 64'(in_ready), 64'd1);
`else
        chk("bp_in_ready", 64'(in_ready), 64'd0);
`endif
        tick();
        tick();
        @(negedge clk);
        chk("bp_hold_data", 64'(out_data), 64'h11);
        chk("bp_hold_occ", 64'(occupancy), 64'd4);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_data", 64'(out_data), 64'h11);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) tick();

        // bubble collapse behind a stalled output item
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h21;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 32'h22;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("bubble_occupancy", 64'(occupancy), 64'd2);
        chk("bubble_out_data", 64'(out_data), 64'h21);
        tick();
        @(negedge clk);
        chk("bubble_occ_hold", 64'(occupancy), 64'd2);
        exp_q.push_back(32'h21);
        exp_q.push_back(32'h22);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();

        // kill stages 1 and 2 while a new item enters
        in_valid = 1'b1;
        in_data  = 32'h31;
        tick();
        in_data = 32'h32;
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("kill_pre_occ", 64'(occupancy), 64'd2);
        flush_mask = 4'b0110;
        in_valid   = 1'b1;
        in_data    = 32'h33;
        exp_q.push_back(32'h33);
        tick();
        flush_mask = '0;
        in_valid   = 1'b0;
        @(negedge clk);
        chk("kill_count_after", 64'(kill_count), 64'd2);
        chk("kill_occupancy", 64'(occupancy), 64'd1);
        for (int k = 0; k < 4; k++) tick();

        // asynchronous reset with three items in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(32'h41 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        #1;
        chk("pre_rst_occ", 64'(occupancy), 64'd3);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_occ", 64'(occupancy), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        chk("async_rst_kill", 64'(kill_count), 64'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        exp_q.push_back(32'h44);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'h44);
        tick();

`ifdef PIPE_STAGE_CHAIN_SKID_BUFFER_EN
        // full chain plus one extra input lands in the skid
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(32'h51 + k);
            exp_q.push_back(WIDTH'(32'h51 + k));
            if (k == 4) begin
                @(negedge clk);
                chk("skid_ready_before", 64'(in_ready), 64'd1);
                chk("skid_full_occ", 64'(occupancy), 64'd4);
            end
            tick();
        end
        in_data = 32'h66;
        @(negedge clk);
        chk("skid_ready_after", 64'(in_ready), 64'd0);
        chk("skid_occ_hold", 64'(occupancy), 64'd4);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
`endif

        chk("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
